// File: rtl/dpu_cmd_pkg.sv
// Shared types and default widths for the DPU command controller.
package dpu_cmd_pkg;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LAYER_W = 4;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_READ  = 2'd2,
        CMD_BURST = 2'd3
    } cmd_e;

    // Controller state encoding, kept as plain constants so older tools can read it.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_BURST   = 3'd1;
    localparam state_t ST_RD_WAIT = 3'd2;
    localparam state_t ST_RD_RSP  = 3'd3;
    localparam state_t ST_RUN     = 3'd4;

endpackage

// File: rtl/dpu_cmd_ctrl.sv
// DPU command controller: memory write/read, burst writes and engine-run sequencing.
// Optional address range check enabled by defining DPU_CMD_ADDR_CHK_EN.
module dpu_cmd_ctrl
    import dpu_cmd_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_SIZE = 2**DEF_ADDR_W,
    parameter int LAYER_W  = DEF_LAYER_W
) (
    input  logic               clk,
    input  logic               rst,
    // valid/ready: a transfer happens on a clk edge where both are high;
    // the sender holds valid and its payload stable until that edge.
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               mem_we,
    output logic               mem_re,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               eng_start,
    output logic [LAYER_W-1:0] eng_layer,
    input  logic               eng_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output state_t             dbg_state
);

    state_t              state_q, state_d;
    logic                rd_phase_q, rd_phase_d;
    logic                rd_oob_q, rd_oob_d;
    logic [DATA_W:0]     remaining_q, remaining_d;
    logic [ADDR_W-1:0]   burst_addr_q, burst_addr_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                eng_start_q, eng_start_d;
    logic [LAYER_W-1:0]  eng_layer_q, eng_layer_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cmd_fire;
    logic                cmd_addr_ok;
    logic                beat_addr_ok;

`ifdef DPU_CMD_ADDR_CHK_EN
    assign cmd_addr_ok  = 64'(cmd_addr) < 64'(MEM_SIZE);
    assign beat_addr_ok = 64'(burst_addr_q) < 64'(MEM_SIZE);
`else
    assign cmd_addr_ok  = 1'b1;
    assign beat_addr_ok = 1'b1;
`endif

    assign cmd_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_BURST));
    assign cmd_fire  = cmd_valid & cmd_ready;

    always_comb begin
        state_d      = state_q;
        rd_phase_d   = rd_phase_q;
        rd_oob_d     = rd_oob_q;
        remaining_d  = remaining_q;
        burst_addr_d = burst_addr_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_data_d   = rsp_data_q;
        eng_start_d  = 1'b0;
        eng_layer_d  = eng_layer_q;
        done_d       = 1'b0;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_e'(cmd_type))
                        CMD_WRITE: begin
                            mem_addr_d  = cmd_addr;
                            mem_wdata_d = cmd_data;
                            mem_we_d    = cmd_addr_ok;
                            err_d       = err_q | ~cmd_addr_ok;
                        end
                        CMD_READ: begin
                            state_d    = ST_RD_WAIT;
                            rd_phase_d = 1'b0;
                            rd_oob_d   = ~cmd_addr_ok;
                            err_d      = err_q | ~cmd_addr_ok;
                            if (cmd_addr_ok) begin
                                mem_re_d   = 1'b1;
                                mem_addr_d = cmd_addr;
                            end
                        end
                        CMD_BURST: begin
                            state_d      = ST_BURST;
                            burst_addr_d = cmd_addr;
                            remaining_d  = {1'b0, cmd_data} + (DATA_W+1)'(1);
                        end
                        CMD_RUN: begin
                            state_d     = ST_RUN;
                            eng_layer_d = cmd_data[LAYER_W-1:0];
                            eng_start_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BURST: begin
                // Beats ignore cmd_type; the header fixed how many follow.
                if (cmd_fire) begin
                    mem_addr_d   = burst_addr_q;
                    mem_wdata_d  = cmd_data;
                    mem_we_d     = beat_addr_ok;
                    err_d        = err_q | ~beat_addr_ok;
                    burst_addr_d = burst_addr_q + ADDR_W'(1);
                    remaining_d  = remaining_q - (DATA_W+1)'(1);
                    if (remaining_q == (DATA_W+1)'(1)) state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // Phase 0 issues mem_re; phase 1 is when the memory returns data.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rsp_data_d = rd_oob_q ? '0 : mem_rdata;
                    state_d    = ST_RD_RSP;
                end
            end
            ST_RD_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            ST_RUN: begin
                // A done coincident with the start pulse belongs to no run of ours.
                if (eng_done && !eng_start_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_phase_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
            remaining_q  <= '0;
            burst_addr_q <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_data_q   <= '0;
            eng_start_q  <= 1'b0;
            eng_layer_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_phase_q   <= rd_phase_d;
            rd_oob_q     <= rd_oob_d;
            remaining_q  <= remaining_d;
            burst_addr_q <= burst_addr_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_data_q   <= rsp_data_d;
            eng_start_q  <= eng_start_d;
            eng_layer_q  <= eng_layer_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_RD_RSP);
    assign busy      = (state_q == ST_RUN);
    assign rsp_data  = rsp_data_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign eng_start = eng_start_q;
    assign eng_layer = eng_layer_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
